fft_band_meter: RTL and testbench

FFT_BAND_METER -- requirements
Module: fft_band_meter

---
 rtl/fft_band_meter.sv | 88 ++++++++
 tb/tb_fft_band_meter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fft_band_meter.sv
// fft_band_meter: drains one FFT frame, sums |re|+|im| per band over the lower half,
// and publishes peak-hold band levels that decay by DECAY per frame.
module fft_band_meter #(
  parameter int WIDTH   = 8,
  parameter int SAMPLES = 512,
  parameter int BANDS   = 8,
  parameter int DECAY   = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [WIDTH-1:0]             i_source_real,
  input  logic [WIDTH-1:0]             i_source_cplx,
  input  logic                         i_source_empty,
  input  logic                         i_source_full,
  output logic                         o_source_strobe,
  output logic [BANDS*(WIDTH+1)-1:0]   o_levels,
  output logic                         o_frame_done,
  output logic                         o_busy
);
  localparam int PER = SAMPLES / 2 / BANDS;
  localparam int SH  = $clog2(PER);
  localparam int CW  = $clog2(SAMPLES);
  localparam int BW  = BANDS > 1 ? $clog2(BANDS) : 1;
  localparam int AW  = WIDTH + 1 + SH;
  localparam logic [WIDTH:0] DEC = (WIDTH+1)'(DECAY);
  typedef enum logic [1:0] {IDLE, DRAIN, PUBLISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] bin;
  logic [WIDTH:0] abs_r, abs_c, mag, mag_q;
  logic mag_en, done, strobe;
  logic [BW-1:0] mag_band;
  logic [AW-1:0] acc [BANDS];
  logic [WIDTH:0] lvl [BANDS], avg [BANDS], dec [BANDS];
  // Sign-extend before negating so the most negative input maps to 2^(WIDTH-1) exactly.
  assign abs_r = i_source_real[WIDTH-1] ? -{i_source_real[WIDTH-1], i_source_real} : {1'b0, i_source_real};
  assign abs_c = i_source_cplx[WIDTH-1] ? -{i_source_cplx[WIDTH-1], i_source_cplx} : {1'b0, i_source_cplx};
  assign mag = abs_r + abs_c;
  always_comb begin
    state_n = state;
    strobe = 1'b0;
    if (state == IDLE) state_n = i_source_full ? DRAIN : IDLE;
    else if (state == DRAIN) begin
      strobe = !i_source_empty && !i_rst;
      state_n = (strobe && &bin) ? PUBLISH : DRAIN;
    end
    else state_n = IDLE;
  end
  always_comb begin
    for (int b = 0; b < BANDS; b++) begin
      avg[b] = (WIDTH+1)'(acc[b] >> SH);
      dec[b] = lvl[b] > DEC ? lvl[b] - DEC : '0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      bin <= '0;
      mag_q <= '0;
      mag_en <= 1'b0;
      mag_band <= '0;
      done <= 1'b0;
      for (int b = 0; b < BANDS; b++) begin
        acc[b] <= '0;
        lvl[b] <= '0;
      end
    end else begin
      state <= state_n;
      done <= state == PUBLISH;
      mag_q <= mag;
      // DC and upper-half bins are popped but never reach an accumulator.
      mag_en <= strobe && bin != '0 && !bin[CW-1];
      mag_band <= BW'(bin >> SH);
      if (strobe) bin <= bin + 1'b1;
      if (state == IDLE && i_source_full) begin
        bin <= '0;
        for (int b = 0; b < BANDS; b++) acc[b] <= '0;
      end else if (mag_en) acc[mag_band] <= acc[mag_band] + AW'(mag_q);
      if (state == PUBLISH)
        for (int b = 0; b < BANDS; b++) lvl[b] <= avg[b] > dec[b] ? avg[b] : dec[b];
    end
  end
  for (genvar b = 0; b < BANDS; b++) begin : g_lv
    assign o_levels[b*(WIDTH+1) +: WIDTH+1] = lvl[b];
  end
  assign o_source_strobe = strobe;
  assign o_frame_done = done && !i_rst;
  assign o_busy = state != IDLE && !i_rst;
endmodule

// File: tb/tb_fft_band_meter.sv
// tb_fft_band_meter: directed frames against hand-computed band levels.
module tb_fft_band_meter;
  localparam int W = 8, N = 512, B = 8;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [W-1:0] i_source_real = '0, i_source_cplx = '0;
  logic i_source_empty = 1'b1, i_source_full = 1'b0;
  logic o_source_strobe, o_frame_done, o_busy;
  logic [B*(W+1)-1:0] o_levels;
  logic [W-1:0] re_m [N], im_m [N];
  int n_chk = 0, n_pass = 0, strobes, gap, stall_bad;
  fft_band_meter #(.WIDTH(W), .SAMPLES(N), .BANDS(B), .DECAY(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_source_real(i_source_real), .i_source_cplx(i_source_cplx),
    .i_source_empty(i_source_empty), .i_source_full(i_source_full), .o_source_strobe(o_source_strobe),
    .o_levels(o_levels), .o_frame_done(o_frame_done), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic fill(input int lo, input int hi, input int re, input int im);
    for (int i = 0; i < N; i++) begin
      re_m[i] = (i >= lo && i <= hi) ? W'(re) : '0;
      im_m[i] = (i >= lo && i <= hi) ? W'(im) : '0;
    end
  endtask
  task automatic lv(input string tag, input int e0, input int e1, input int er);
    for (int b = 0; b < B; b++)
      check($sformatf("%s_band%0d", tag, b), 32'(o_levels[b*(W+1) +: W+1]), b == 0 ? e0 : b == 1 ? e1 : er);
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    i_source_empty = 1'b0;
    i_source_full = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      check("rst_strobe", o_source_strobe, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_frame_done, 0);
      @(posedge i_clk); #1;
    end
    i_rst = 1'b0;
    i_source_empty = 1'b1;
    i_source_full = 1'b0;
    @(negedge i_clk);
    check("post_rst_strobe", o_source_strobe, 0);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_done", o_frame_done, 0);
    @(posedge i_clk); #1;
  endtask
  task automatic run(input int stall_at, input int stop_at);
    int ptr, stalls, last, done_at;
    logic st;
    ptr = 0; stalls = 0; last = -1; done_at = -1;
    strobes = 0; stall_bad = 0;
    for (int cyc = 0; cyc < 2000 && done_at < 0 && ptr != stop_at; cyc++) begin
      st = ptr == stall_at && stalls < 5;
      i_source_empty = ptr >= N || st;
      i_source_full = ptr == 0;
      i_source_real = re_m[ptr % N];
      i_source_cplx = im_m[ptr % N];
      @(negedge i_clk);
      if (st) begin
        stalls++;
        if (o_source_strobe) stall_bad++;
      end
      if (o_source_strobe) begin
        strobes++;
        last = cyc;
        ptr++;
      end
      if (o_frame_done) done_at = cyc;
      @(posedge i_clk); #1;
    end
    i_source_full = 1'b0;
    i_source_empty = 1'b1;
    gap = done_at < 0 ? -1 : done_at - last;
  endtask
  task automatic frame_checks(input string tag);
    check({tag, "_strobes"}, strobes, N);
    check({tag, "_done_gap"}, gap, 2);
    @(negedge i_clk);
    check({tag, "_done_pulse"}, o_frame_done, 0);
    check({tag, "_idle"}, o_busy, 0);
    @(posedge i_clk); #1;
  endtask
  initial begin
    @(posedge i_clk); #1;
    do_reset();
    lv("reset", 0, 0, 0);
    fill(0, N-1, 10, -6);
    run(-1, -1);
    frame_checks("uniform");
    lv("uniform", 15, 16, 16);
    do_reset();
    fill(40, 40, -128, -128);
    run(-1, -1);
    frame_checks("impulse");
    lv("impulse", 0, 8, 0);
    fill(1, 0, 0, 0);
    run(-1, -1);
    frame_checks("decay1");
    lv("decay1", 0, 7, 0);
    run(-1, -1);
    lv("decay2", 0, 6, 0);
    do_reset();
    fill(0, N-1, 10, -6);
    run(100, -1);
    check("stall_strobe_low", stall_bad, 0);
    frame_checks("stall");
    lv("stall", 15, 16, 16);
    run(-1, 200);
    check("midrst_popped", strobes, 200);
    do_reset();
    lv("midrst", 0, 0, 0);
    run(-1, -1);
    frame_checks("after_rst");
    lv("after_rst", 15, 16, 16);
    do_reset();
    fill(256, N-1, 50, 0);
    run(-1, -1);
    frame_checks("upper");
    lv("upper", 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
